// File: rtl/asteroid_mover.sv
// asteroid_mover: tick-paced X/Y offset generator for one falling asteroid sprite.
// Define ASTEROID_DIAG_EN for diagonal fall; otherwise xmovaddr is constant 0.
module asteroid_mover #(
    parameter int TICK_DIV = 416667,
    parameter int YSTEP    = 2,
    parameter int XSTEP    = 1,
    parameter int Y_LIMIT  = 480
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       halt,
    input  logic       restart,
    input  logic       asteroid_on,
    output logic [9:0] xmovaddr,
    output logic [9:0] ymovaddr
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CMAX = CW'(TICK_DIV - 1);
    localparam logic [10:0] YS = 11'(YSTEP);
    localparam logic [10:0] YL = 11'(Y_LIMIT);

    typedef enum logic {IDLE, FALL} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [9:0]    y, y_n;
    logic [10:0]   y_sum;
    logic          step, wrap;

    // One extra bit so the limit compare cannot be fooled by 10-bit wrap.
    assign y_sum = {1'b0, y} + YS;
    assign step  = state == FALL && cnt == CMAX;
    assign wrap  = y_sum >= YL;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        y_n     = y;
        if (restart) begin
            state_n = IDLE;
            cnt_n   = '0;
            y_n     = '0;
        end else if (!halt) begin
            if (state == IDLE) begin
                state_n = asteroid_on ? FALL : IDLE;
                cnt_n   = '0;
                y_n     = '0;
            end else if (!step) begin
                cnt_n = cnt + 1'b1;
            end else begin
                cnt_n   = '0;
                state_n = wrap ? IDLE : FALL;
                y_n     = wrap ? 10'd0 : y_sum[9:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            y     <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            y     <= y_n;
        end
    end

    assign ymovaddr = y;

`ifdef ASTEROID_DIAG_EN
    logic [9:0] x, x_n;

    // X follows exactly the same hold/clear/step decisions as Y.
    always_comb begin
        x_n = x;
        if (restart) begin
            x_n = '0;
        end else if (!halt) begin
            if (state == IDLE) begin
                x_n = '0;
            end else if (step) begin
                x_n = wrap ? 10'd0 : x + 10'(XSTEP);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x <= '0;
        end else begin
            x <= x_n;
        end
    end

    assign xmovaddr = x;
`else
    assign xmovaddr = 10'(XSTEP * 0);
`endif
endmodule

// File: tb/tb_asteroid_mover.sv
// tb_asteroid_mover: directed scenarios plus randomized stimulus checked every cycle
// against a step-count model of the asteroid's fall.
module tb_asteroid_mover;
    localparam int TD = 4;
    localparam int YS = 2;
    localparam int XS = 1;
    localparam int YL = 8;
`ifdef ASTEROID_DIAG_EN
    localparam int DIAG = 1;
`else
    localparam int DIAG = 0;
`endif

    logic       clk = 0;
    logic       reset_n = 0;
    logic       halt = 0;
    logic       restart = 0;
    logic       asteroid_on = 0;
    logic [9:0] xmovaddr, ymovaddr;

    int checks = 0;
    int errors = 0;

    asteroid_mover #(.TICK_DIV(TD), .YSTEP(YS), .XSTEP(XS), .Y_LIMIT(YL)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .halt(halt),
        .restart(restart),
        .asteroid_on(asteroid_on),
        .xmovaddr(xmovaddr),
        .ymovaddr(ymovaddr)
    );

    always #5 clk = ~clk;

    // Model: whether a fall is in progress, clocks since the last step, steps taken.
    bit m_active;
    int m_elapsed;
    int m_steps;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n || restart) begin
            m_active  <= 0;
            m_elapsed <= 0;
            m_steps   <= 0;
        end else if (halt) begin
        end else if (!m_active) begin
            m_active  <= asteroid_on;
            m_elapsed <= 0;
            m_steps   <= 0;
        end else if (m_elapsed + 1 < TD) begin
            m_elapsed <= m_elapsed + 1;
        end else begin
            m_elapsed <= 0;
            if ((m_steps + 1) * YS >= YL) begin
                m_active <= 0;
                m_steps  <= 0;
            end else begin
                m_steps <= m_steps + 1;
            end
        end
    end

    function automatic int exp_x(input int k);
        return DIAG ? (k * XS) % 1024 : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_y", 32'(ymovaddr), 32'(m_steps * YS));
        chk("model_x", 32'(xmovaddr), 32'(exp_x(m_steps)));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tick(2);
        chk("reset_y", 32'(ymovaddr), 0);
        chk("reset_x", 32'(xmovaddr), 0);
        reset_n = 1;

        asteroid_on = 1;
        tick(1);
        asteroid_on = 0;
        tick(4);
        chk("fall_y2", 32'(ymovaddr), 2);
        chk("fall_x1", 32'(xmovaddr), 32'(exp_x(1)));
        tick(4);
        chk("fall_y4", 32'(ymovaddr), 4);
        tick(4);
        chk("fall_y6", 32'(ymovaddr), 6);
        chk("fall_x3", 32'(xmovaddr), 32'(exp_x(3)));
        tick(4);
        chk("fall_end_y", 32'(ymovaddr), 0);
        chk("fall_end_x", 32'(xmovaddr), 0);

        asteroid_on = 1;
        tick(1);
        asteroid_on = 0;
        tick(11);
        halt = 1;
        tick(10);
        chk("halt_y", 32'(ymovaddr), 4);
        chk("halt_x", 32'(xmovaddr), 32'(exp_x(2)));
        halt = 0;
        tick(1);
        chk("unhalt_y", 32'(ymovaddr), 6);

        restart = 1;
        halt = 1;
        asteroid_on = 1;
        tick(1);
        chk("restart_y", 32'(ymovaddr), 0);
        chk("restart_x", 32'(xmovaddr), 0);
        restart = 0;
        halt = 0;
        asteroid_on = 0;
        tick(6);
        chk("restart_nospawn_y", 32'(ymovaddr), 0);

        asteroid_on = 1;
        tick(17);
        chk("cont_wrap_y", 32'(ymovaddr), 0);
        tick(4);
        chk("cont_pre_y", 32'(ymovaddr), 0);
        tick(1);
        chk("cont_y2", 32'(ymovaddr), 2);
        asteroid_on = 0;
        tick(12);
        chk("cont_end_y", 32'(ymovaddr), 0);

        asteroid_on = 1;
        tick(1);
        asteroid_on = 0;
        tick(12);
        chk("midfall_y6", 32'(ymovaddr), 6);
        #2 reset_n = 0;
        #1;
        chk("async_rst_y", 32'(ymovaddr), 0);
        chk("async_rst_x", 32'(xmovaddr), 0);
        tick(2);
        reset_n = 1;
        tick(4);
        chk("post_rst_y", 32'(ymovaddr), 0);

        repeat (4000) begin
            @(negedge clk);
            #1;
            reset_n     = $urandom_range(0, 249) != 0;
            asteroid_on = $urandom_range(0, 3) != 0;
            halt        = $urandom_range(0, 9) == 0;
            restart     = $urandom_range(0, 39) == 0;
        end
        reset_n = 1;
        halt = 0;
        restart = 0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
